// File: rtl/word_scroll_pkg.sv
// Shared types and helpers for the word scroll controller.
// Holds the load FSM encoding and the index-width helper.
package word_scroll_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOADED = 1'b1
  } load_state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/word_scroll_controller_tick_gen.sv
// Auto-scroll step generator: one-cycle tick every PERIOD
// enabled cycles, restartable from the controller.
module scroll_tick_gen
  import word_scroll_pkg::*;
#(
  parameter int PERIOD = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count_q, count_d;

  // Counter idles at zero while disabled, so the cycle
  // auto_en rises is the first cycle of a fresh period.
  always_comb begin
    count_d = '0;
    tick    = 1'b0;
    if (en && !restart) begin
      if (count_q == LAST) begin
        tick = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/word_scroll_controller.sv
// Word scroll controller: buffers a sentence and steps
// through its words manually or on an auto-scroll timer.
module word_scroll_controller
  import word_scroll_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int NUM_WORDS   = 8,
  parameter int WRAP        = 1,
  parameter int AUTO_PERIOD = 50_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WORD_W*NUM_WORDS-1:0]   sentence,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic                          next_word,
  input  logic                          prev_word,
  input  logic                          auto_en,
  output logic [WORD_W-1:0]             current_word,
  output logic [idx_w(NUM_WORDS)-1:0]   word_index,
  output logic                          at_first,
  output logic                          at_last
);

  localparam int IW = idx_w(NUM_WORDS);
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  load_state_e       state_q, state_d;
  logic [WORD_W-1:0] sent_w [NUM_WORDS];
  logic [WORD_W-1:0] buf_q  [NUM_WORDS];
  logic [WORD_W-1:0] buf_d  [NUM_WORDS];
  logic [IW-1:0]     index_q, index_d;
  logic              at_first_q, at_first_d;
  logic              at_last_q, at_last_d;
  logic              accept;
  logic              restart;
  logic              tick;
  logic              step_fwd;
  logic              step_back;

  // Word 0 sits in the MSBs of the packed sentence.
  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_split
    assign sent_w[g] =
      sentence[(NUM_WORDS-1-g)*WORD_W +: WORD_W];
  end

  assign load_ready = (state_q == IDLE);
  assign accept     = load_valid && load_ready;
  assign restart    = accept || next_word || prev_word;

  scroll_tick_gen #(
    .PERIOD (AUTO_PERIOD)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (auto_en),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOADED;
      LOADED:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A manual step restarts the timer, so tick never
  // coincides with next_word/prev_word or a load.
  always_comb begin
    step_fwd  = 1'b0;
    step_back = 1'b0;
    if (!accept) begin
      unique case (1'b1)
        (next_word && !prev_word): step_fwd  = 1'b1;
        (prev_word && !next_word): step_back = 1'b1;
        tick:                      step_fwd  = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    index_d = index_q;
    buf_d   = buf_q;
    if (accept) begin
      index_d = '0;
      buf_d   = sent_w;
    end else if (step_fwd) begin
      if (index_q == LAST) begin
        index_d = (WRAP != 0) ? '0 : LAST;
      end else begin
        index_d = index_q + IW'(1);
      end
    end else if (step_back) begin
      if (index_q == '0) begin
        index_d = (WRAP != 0) ? LAST : '0;
      end else begin
        index_d = index_q - IW'(1);
      end
    end
    at_first_d = (index_d == '0);
    at_last_d  = (index_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      buf_q      <= '{default: '0};
      index_q    <= '0;
      at_first_q <= 1'b1;
      at_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      index_q    <= index_d;
      at_first_q <= at_first_d;
      at_last_q  <= at_last_d;
    end
  end

  assign current_word = buf_q[index_q];
  assign word_index   = index_q;
  assign at_first     = at_first_q;
  assign at_last      = at_last_q;

endmodule

// File: tb/tb_word_scroll_controller.sv
// Bench for word_scroll_controller: two configurations
// (wrapping 8-word, saturating 5-word) against a model.
module tb_word_scroll_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic load_valid;
  logic next_word;
  logic prev_word;
  logic auto_en;
  logic [255:0] sent_a;
  logic [159:0] sent_b;
  logic a_rdy, a_first, a_last;
  logic b_rdy, b_first, b_last;
  logic [31:0] a_cw, b_cw;
  logic [2:0] a_idx, b_idx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  word_scroll_controller #(
    .WORD_W(32), .NUM_WORDS(8), .WRAP(1), .AUTO_PERIOD(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .sentence(sent_a),
    .load_valid(load_valid), .load_ready(a_rdy),
    .next_word(next_word), .prev_word(prev_word),
    .auto_en(auto_en), .current_word(a_cw),
    .word_index(a_idx), .at_first(a_first),
    .at_last(a_last)
  );

  word_scroll_controller #(
    .WORD_W(32), .NUM_WORDS(5), .WRAP(0), .AUTO_PERIOD(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .sentence(sent_b),
    .load_valid(load_valid), .load_ready(b_rdy),
    .next_word(next_word), .prev_word(prev_word),
    .auto_en(auto_en), .current_word(b_cw),
    .word_index(b_idx), .at_first(b_first),
    .at_last(b_last)
  );

  // Reference model: word list, index, ready flag, and the
  // cycle at which the current auto period began.
  int          nw[2]   = '{8, 5};
  int          wr[2]   = '{1, 0};
  int          per[2]  = '{4, 3};
  int unsigned mw[2][8];
  int          midx[2];
  bit          mrdy[2];
  int          mstart[2];
  bit          auto_prev;
  int          cyc = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int fwd(input int k, input int i);
    if (i == nw[k] - 1) return (wr[k] != 0) ? 0 : i;
    return i + 1;
  endfunction

  function automatic int back(input int k, input int i);
    if (i == 0) return (wr[k] != 0) ? nw[k] - 1 : 0;
    return i - 1;
  endfunction

  task automatic model_update();
    bit acc, manual, rise, fire;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        midx[k] = 0;
        mrdy[k] = 1'b1;
        mstart[k] = 0;
        for (int i = 0; i < 8; i++) mw[k][i] = 0;
      end
      auto_prev = 1'b0;
      cyc++;
      return;
    end
    manual = next_word || prev_word;
    rise   = auto_en && !auto_prev;
    for (int k = 0; k < 2; k++) begin
      acc = load_valid && mrdy[k];
      if (rise) mstart[k] = cyc;
      fire = auto_en && !acc && !manual &&
             ((cyc - mstart[k]) % per[k] == per[k] - 1);
      if (acc) begin
        for (int i = 0; i < nw[k]; i++) begin
          if (k == 0) mw[k][i] = sent_a[(7 - i) * 32 +: 32];
          else        mw[k][i] = sent_b[(4 - i) * 32 +: 32];
        end
        midx[k]   = 0;
        mrdy[k]   = 1'b0;
        mstart[k] = cyc + 1;
      end else begin
        mrdy[k] = 1'b1;
        if (manual) mstart[k] = cyc + 1;
        if (next_word && !prev_word)      midx[k] = fwd(k, midx[k]);
        else if (prev_word && !next_word) midx[k] = back(k, midx[k]);
        else if (fire)                    midx[k] = fwd(k, midx[k]);
      end
    end
    auto_prev = auto_en;
    cyc++;
  endtask

  task automatic check_all();
    check("a_idx", 32'(a_idx), 32'(midx[0]));
    check("a_word", a_cw, mw[0][midx[0]]);
    check("a_first", 32'(a_first), 32'(midx[0] == 0));
    check("a_last", 32'(a_last), 32'(midx[0] == 7));
    check("a_ready", 32'(a_rdy), 32'(mrdy[0]));
    check("b_idx", 32'(b_idx), 32'(midx[1]));
    check("b_word", b_cw, mw[1][midx[1]]);
    check("b_first", 32'(b_first), 32'(midx[1] == 0));
    check("b_last", 32'(b_last), 32'(midx[1] == 4));
    check("b_ready", 32'(b_rdy), 32'(mrdy[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic pulse(input bit n, input bit p);
    next_word = n;
    prev_word = p;
    step();
    next_word = 1'b0;
    prev_word = 1'b0;
  endtask

  task automatic do_load();
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    next_word  = 1'b0;
    prev_word  = 1'b0;
    auto_en    = 1'b0;
    sent_a = {32'h11111111, 32'h22222222, 32'h33333333,
              32'h44444444, 32'h55555555, 32'h66666666,
              32'h77777777, 32'h88888888};
    sent_b = {32'h11111111, 32'h22222222, 32'h33333333,
              32'h44444444, 32'h55555555};
    repeat (2) step();
    check("rst_first", 32'(a_first), 32'd1);
    check("rst_ready", 32'(a_rdy), 32'd1);
    rst_n = 1'b1;
    step();

    do_load();
    check("load_idx", 32'(a_idx), 32'd0);
    check("load_word", a_cw, 32'h11111111);
    check("load_busy", 32'(a_rdy), 32'd0);
    step();
    check("load_ready_back", 32'(a_rdy), 32'd1);

    repeat (6) pulse(1'b1, 1'b0);
    check("sat_idx", 32'(b_idx), 32'd4);
    check("sat_last", 32'(b_last), 32'd1);
    repeat (2) pulse(1'b1, 1'b0);
    check("wrap_idx", 32'(a_idx), 32'd0);

    do_load();
    pulse(1'b0, 1'b1);
    check("wrap_back_idx", 32'(a_idx), 32'd7);
    check("wrap_back_last", 32'(a_last), 32'd1);
    check("sat_back_idx", 32'(b_idx), 32'd0);

    do_load();
    repeat (3) pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    check("both_idx", 32'(a_idx), 32'd3);

    do_load();
    auto_en = 1'b1;
    repeat (12) step();
    auto_en = 1'b0;
    check("auto_idx", 32'(a_idx), 32'd3);

    do_load();
    auto_en = 1'b1;
    repeat (2) step();
    pulse(1'b1, 1'b0);
    repeat (9) step();
    auto_en = 1'b0;
    check("auto_manual_idx", 32'(a_idx), 32'd3);

    do_load();
    repeat (5) pulse(1'b1, 1'b0);
    check("pre_rst_idx", 32'(a_idx), 32'd5);
    auto_en = 1'b1;
    repeat (2) step();
    #2;
    rst_n      = 1'b0;
    load_valid = 1'b1;
    #1;
    check("async_idx", 32'(a_idx), 32'd0);
    check("async_word", a_cw, 32'd0);
    check("async_first", 32'(a_first), 32'd1);
    check("async_last", 32'(a_last), 32'd0);
    check("async_ready", 32'(a_rdy), 32'd1);
    step();
    load_valid = 1'b0;
    auto_en    = 1'b0;
    rst_n      = 1'b1;
    step();

    for (int c = 0; c < 400; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      next_word  = (r < 15);
      prev_word  = (r >= 10 && r < 25);
      load_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
      rst_n = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < 8; i++) sent_a[i*32 +: 32] = $urandom();
      for (int i = 0; i < 5; i++) sent_b[i*32 +: 32] = $urandom();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
